// File: rtl/bsg_gateway_clk_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bsg_gateway_clk_pkg
// Purpose : Shared types and constants for the gateway DCM_CLKGEN
//           programming controller: FSM state encoding, completion error
//           codes and the serial command framing (2-bit header + 8-bit
//           payload, shifted LSB first).
// Revision: 1.0 - initial release
// ============================================================================
package bsg_gateway_clk_pkg;

  typedef enum logic [3:0] {
    e_idle      = 4'd0,
    e_load_d    = 4'd1,
    e_gap_d     = 4'd2,
    e_load_m    = 4'd3,
    e_gap_m     = 4'd4,
    e_go        = 4'd5,
    e_wait_done = 4'd6,
    e_wait_lock = 4'd7,
    e_report    = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    e_err_ok      = 2'd0,
    e_err_bad_req = 2'd1,
    e_err_done_to = 2'd2,
    e_err_lock_to = 2'd3
  } err_e;

  // Command headers; bit0 goes out on the wire first.
  localparam logic [1:0] c_CMD_LOAD_D = 2'b01;
  localparam logic [1:0] c_CMD_LOAD_M = 2'b11;

  // Total bits per command: 2 header + 8 payload.
  localparam int c_CMD_LEN = 10;

  // Assemble a command word so that shifting it out LSB first yields the
  // header (bit0, bit1) followed by payload[0]..payload[7].
  function automatic logic [c_CMD_LEN-1:0] cmd_word(input logic [1:0] hdr,
                                                    input logic [7:0] payload);
    return {payload, hdr};
  endfunction

endpackage : bsg_gateway_clk_pkg
`default_nettype wire

// File: rtl/bsg_gateway_dcm_prog_shifter.sv
`default_nettype none
// ============================================================================
// Module  : bsg_gateway_dcm_prog_shifter
// Purpose : 10-bit parallel-load, LSB-first shift register with bit counter.
//           Used back to back for the LoadD and LoadM commands. Zeros are
//           shifted in, so once a command has gone out bit_o rests at 0,
//           which is what PROGDATA needs during gaps, GO and waits.
// Ports   : clk_i     - clock
//           reset_n_i - asynchronous active-low reset
//           load_i    - capture data_i, restart the bit counter
//           data_i    - command word (bit0 is sent first)
//           shift_i   - advance one bit
//           bit_o     - current serial bit (direct flop output)
//           last_o    - high while the final bit of the word is on bit_o
// Revision: 1.0 - initial release
// ============================================================================
module bsg_gateway_dcm_prog_shifter
  import bsg_gateway_clk_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 load_i,
  input  logic [c_CMD_LEN-1:0] data_i,
  input  logic                 shift_i,
  output logic                 bit_o,
  output logic                 last_o
);

  localparam int c_CNT_W = $clog2(c_CMD_LEN + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_END  = c_CNT_W'(c_CMD_LEN);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_CMD_LEN - 1);

  logic [c_CMD_LEN-1:0] r_data;
  logic [c_CNT_W-1:0]   r_cnt;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_data <= '0;
      r_cnt  <= c_CNT_END;
    end else if (load_i) begin
      r_data <= data_i;
      r_cnt  <= '0;
    end else if (shift_i) begin
      r_data <= {1'b0, r_data[c_CMD_LEN-1:1]};
      // Park at the end value so last_o cannot re-fire after the word.
      if (r_cnt != c_CNT_END) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bit_o  = r_data[0];
  assign last_o = (r_cnt == c_CNT_LAST);

endmodule : bsg_gateway_dcm_prog_shifter
`default_nettype wire

// File: rtl/bsg_gateway_dcm_prog.sv
`default_nettype none
// ============================================================================
// Module  : bsg_gateway_dcm_prog
// Purpose : Serial programming controller for the gateway DCM_CLKGEN that
//           generates the tag / microblaze clock. Accepts an M-1 / D-1 pair,
//           shifts LoadD, LoadM and GO onto PROGEN/PROGDATA, then waits for
//           PROGDONE and LOCKED and reports a completion status.
//           clk_i is also the DCM PROGCLK and must be free running (never
//           sourced from the DCM being programmed).
// Ports   : clk_i        - programming clock / PROGCLK
//           reset_n_i    - asynchronous active-low reset
//           v_i          - request valid (taken when ready_o is high)
//           mult_m1_i    - CLKFX_MULTIPLY-1, 1..255 legal
//           div_m1_i     - CLKFX_DIVIDE-1, 0..255 legal
//           ready_o      - idle, request may be accepted
//           prog_en_o    - DCM PROGEN
//           prog_data_o  - DCM PROGDATA
//           prog_done_i  - DCM PROGDONE (synchronous to clk_i)
//           dcm_locked_i - DCM LOCKED (asynchronous, synchronized here)
//           done_v_o     - one-cycle completion pulse
//           done_err_o   - 0 ok, 1 bad request, 2 PROGDONE timeout,
//                          3 lock timeout (valid with done_v_o)
//           busy_o       - sequence in progress
// Revision: 1.0 - initial release
// ============================================================================
module bsg_gateway_dcm_prog
  import bsg_gateway_clk_pkg::*;
#(
  parameter int done_timeout_p = 1024,
  parameter int lock_timeout_p = 65536,
  parameter int gap_cycles_p   = 2
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       v_i,
  input  logic [7:0] mult_m1_i,
  input  logic [7:0] div_m1_i,
  output logic       ready_o,
  output logic       prog_en_o,
  output logic       prog_data_o,
  input  logic       prog_done_i,
  input  logic       dcm_locked_i,
  output logic       done_v_o,
  output logic [1:0] done_err_o,
  output logic       busy_o
);

  // A gap shorter than one cycle would merge commands on the wire.
  localparam int c_GAP      = (gap_cycles_p < 1) ? 1 : gap_cycles_p;
  localparam int c_MAX_TO   = (done_timeout_p > lock_timeout_p) ? done_timeout_p
                                                                : lock_timeout_p;
  localparam int c_MAX_CNT  = (c_MAX_TO > c_GAP) ? c_MAX_TO : c_GAP;
  localparam int c_CNT_W    = $clog2(c_MAX_CNT + 1);

  // The counter holds the number of cycles already spent in the current
  // state, so "last" values are the limits minus one.
  localparam logic [c_CNT_W-1:0] c_DONE_LAST = c_CNT_W'(done_timeout_p - 1);
  localparam logic [c_CNT_W-1:0] c_LOCK_LAST = c_CNT_W'(lock_timeout_p - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(c_GAP - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_SAT   = '1;

  state_e               r_state;
  state_e               w_state_next;
  err_e                 w_err_next;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [7:0]           r_mult;
  logic                 r_lock_s1;
  logic                 r_lock_s2;
  logic                 w_accept;

  logic                 w_sh_load;
  logic                 w_sh_shift;
  logic [c_CMD_LEN-1:0] w_sh_word;
  logic                 w_sh_last;

  logic                 w_ready_next;
  logic                 w_en_next;
  logic                 w_busy_next;
  logic                 w_done_v_next;
  logic [1:0]           w_err_out_next;

  assign w_accept = v_i & ready_o;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= e_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_err_next   = e_err_ok;
    unique case (r_state)
      e_idle: begin
        if (w_accept) begin
          if (mult_m1_i == 8'd0) begin
            w_state_next = e_report;
            w_err_next   = e_err_bad_req;
          end else begin
            w_state_next = e_load_d;
          end
        end
      end
      e_load_d:  if (w_sh_last) w_state_next = e_gap_d;
      e_gap_d:   if (r_cnt == c_GAP_LAST) w_state_next = e_load_m;
      e_load_m:  if (w_sh_last) w_state_next = e_gap_m;
      e_gap_m:   if (r_cnt == c_GAP_LAST) w_state_next = e_go;
      e_go:      w_state_next = e_wait_done;
      e_wait_done: begin
        // PROGDONE wins over a coincident timeout.
        if (prog_done_i) begin
          w_state_next = e_wait_lock;
        end else if (r_cnt >= c_DONE_LAST) begin
          w_state_next = e_report;
          w_err_next   = e_err_done_to;
        end
      end
      e_wait_lock: begin
        if (r_lock_s2) begin
          w_state_next = e_report;
          w_err_next   = e_err_ok;
        end else if (r_cnt >= c_LOCK_LAST) begin
          w_state_next = e_report;
          w_err_next   = e_err_lock_to;
        end
      end
      e_report:  w_state_next = e_idle;
      default:   w_state_next = e_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode from the next state; the flops below make every output
  // line up with the state it belongs to.
  // --------------------------------------------------------------------------
  always_comb begin
    w_ready_next   = (w_state_next == e_idle);
    w_en_next      = (w_state_next == e_load_d) || (w_state_next == e_load_m)
                  || (w_state_next == e_go);
    w_busy_next    = (w_state_next != e_idle) && (w_state_next != e_report);
    w_done_v_next  = (w_state_next == e_report);
    w_err_out_next = w_done_v_next ? w_err_next : 2'd0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ready_o    <= 1'b1;
      prog_en_o  <= 1'b0;
      busy_o     <= 1'b0;
      done_v_o   <= 1'b0;
      done_err_o <= 2'd0;
    end else begin
      ready_o    <= w_ready_next;
      prog_en_o  <= w_en_next;
      busy_o     <= w_busy_next;
      done_v_o   <= w_done_v_next;
      done_err_o <= w_err_out_next;
    end
  end

  // --------------------------------------------------------------------------
  // Per-state cycle counter: cleared on every state change, saturating.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cnt <= '0;
    end else if (w_state_next != r_state) begin
      r_cnt <= '0;
    end else if (r_cnt != c_CNT_SAT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Request capture and LOCKED synchronizer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_mult <= 8'd0;
    end else if (r_state == e_idle && w_accept) begin
      r_mult <= mult_m1_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_lock_s1 <= 1'b0;
      r_lock_s2 <= 1'b0;
    end else begin
      r_lock_s1 <= dcm_locked_i;
      r_lock_s2 <= r_lock_s1;
    end
  end

  // --------------------------------------------------------------------------
  // Command shifter. The D word is captured straight from the request on the
  // accept edge (that is its latch); the M word is loaded on the edge that
  // leaves GAP_D, so bit0 of each command is on the wire in the first cycle
  // of its LOAD state.
  // --------------------------------------------------------------------------
  assign w_sh_load  = ((r_state == e_idle)  && (w_state_next == e_load_d))
                   || ((r_state == e_gap_d) && (w_state_next == e_load_m));
  assign w_sh_shift = (r_state == e_load_d) || (r_state == e_load_m);
  assign w_sh_word  = (r_state == e_idle) ? cmd_word(c_CMD_LOAD_D, div_m1_i)
                                          : cmd_word(c_CMD_LOAD_M, r_mult);

  bsg_gateway_dcm_prog_shifter u_shifter (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .load_i    (w_sh_load),
    .data_i    (w_sh_word),
    .shift_i   (w_sh_shift),
    .bit_o     (prog_data_o),
    .last_o    (w_sh_last)
  );

endmodule : bsg_gateway_dcm_prog
`default_nettype wire
